// File: rtl/output_stage_pkg.sv
// -----------------------------------------------------------------------------
// output_stage_pkg
// Shared definitions for the output stage:
//   state_e    - FIFO occupancy state (EMPTY / ONE / FULL)
//   DEPTH      - number of result slots in the FIFO
//   Z_W        - residue width carried through the stage
//   CNT_W      - width of the delivered-results counter
//   even_par() - even parity over a {s, z} entry
// -----------------------------------------------------------------------------
package output_stage_pkg;

    localparam int DEPTH = 2;
    localparam int Z_W   = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Even parity bit: makes the total number of ones in {par, v} even.
    function automatic logic even_par(input logic [Z_W:0] v);
        return ^v;
    endfunction

endpackage : output_stage_pkg

// File: rtl/result_slot.sv
// -----------------------------------------------------------------------------
// result_slot
// One FIFO entry holding {s, z}. When load=1 the entry captures d_*; otherwise
// it holds its value. Optional parity bit is built only when
// OUTPUT_STAGE_PARITY_EN is defined.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   load          - capture d_* on the next rising edge
//   d_s, d_z      - incoming tag and residue
//   d_par         - incoming parity (OUTPUT_STAGE_PARITY_EN only)
//   q_s, q_z      - stored tag and residue
//   q_par         - stored parity (OUTPUT_STAGE_PARITY_EN only)
// -----------------------------------------------------------------------------
module result_slot
    import output_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           d_s,
    input  logic [Z_W-1:0] d_z,
`ifdef OUTPUT_STAGE_PARITY_EN
    input  logic           d_par,
    output logic           q_par,
`endif
    output logic           q_s,
    output logic [Z_W-1:0] q_z
);

    logic           s_d, s_q;
    logic [Z_W-1:0] z_d, z_q;

    always_comb begin
        s_d = s_q;
        z_d = z_q;
        if (load) begin
            s_d = d_s;
            z_d = d_z;
        end
    end

    // NOTE: storage is reset because the head slot drives out_z/out_s directly
    // and those outputs must read zero while reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= 1'b0;
            z_q <= '0;
        end else begin
            s_q <= s_d;
            z_q <= z_d;
        end
    end

    assign q_s = s_q;
    assign q_z = z_q;

`ifdef OUTPUT_STAGE_PARITY_EN
    logic par_d, par_q;

    always_comb begin
        par_d = par_q;
        if (load) begin
            par_d = d_par;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign q_par = par_q;
`endif

endmodule : result_slot

// File: rtl/output_stage.sv
// -----------------------------------------------------------------------------
// output_stage
// Two-entry shift FIFO buffering third-stage residue results {s, z} for a
// valid/ready consumer. Slot 0 is always the head; slot 1 holds the second
// entry and shifts into slot 0 on a pop from FULL.
// Optional feature macro: OUTPUT_STAGE_PARITY_EN adds out_par, the even parity
// of {out_s, out_z}, computed at push time and stored with each entry.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid          - z3..z0 / s carry a result this cycle
//   z3, z2, z1, z0    - residue bits, z3 = MSB
//   s                 - operation tag (0 = add, 1 = subtract)
//   in_ready          - stage can accept a result (0 only when FULL)
//   out_valid         - out_z/out_s present a result
//   out_ready         - consumer accepts the presented result
//   out_z, out_s      - oldest buffered entry
//   out_par           - stored parity of the head entry (macro only)
//   drop_err          - sticky: a result was offered while in_ready=0
//   res_count         - results delivered, modulo 256
// -----------------------------------------------------------------------------
module output_stage
    import output_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             z3,
    input  logic             z2,
    input  logic             z1,
    input  logic             z0,
    input  logic             s,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Z_W-1:0]   out_z,
    output logic             out_s,
`ifdef OUTPUT_STAGE_PARITY_EN
    output logic             out_par,
`endif
    output logic             drop_err,
    output logic [CNT_W-1:0] res_count
);

    state_e           state_d, state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             drop_err_d, drop_err_q;
    logic [CNT_W-1:0] res_count_d, res_count_q;

    logic [Z_W-1:0]   in_z;
    logic             push;
    logic             pop;

    logic             slot_load [DEPTH];
    logic             slot_d_s  [DEPTH];
    logic [Z_W-1:0]   slot_d_z  [DEPTH];
    logic             slot_s    [DEPTH];
    logic [Z_W-1:0]   slot_z    [DEPTH];

    assign in_z = {z3, z2, z1, z0};

    // Handshakes use registered ready/valid only, so there is no
    // combinational path from out_ready back to in_ready.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        drop_err_d   = drop_err_q;
        res_count_d  = res_count_q;
        slot_load[0] = 1'b0;
        slot_load[1] = 1'b0;

        // Slot 0 refills from slot 1 when draining FULL, else from the input.
        slot_d_s[0]  = (state_q == FULL) ? slot_s[1] : s;
        slot_d_z[0]  = (state_q == FULL) ? slot_z[1] : in_z;
        slot_d_s[1]  = s;
        slot_d_z[1]  = in_z;

        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    slot_load[0] = 1'b1;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Head leaves and the new entry becomes the head.
                    slot_load[0] = 1'b1;
                end else if (push) begin
                    slot_load[1] = 1'b1;
                    state_d      = FULL;
                end else if (pop) begin
                    state_d      = EMPTY;
                end
            end
            FULL: begin
                // An offer while full is never accepted, even alongside a pop.
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end
                if (pop) begin
                    slot_load[0] = 1'b1;
                    state_d      = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (pop) begin
            res_count_d = res_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            drop_err_q  <= 1'b0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            drop_err_q  <= drop_err_d;
            res_count_q <= res_count_d;
        end
    end

`ifdef OUTPUT_STAGE_PARITY_EN
    logic slot_d_par [DEPTH];
    logic slot_par   [DEPTH];
    logic in_par;

    assign in_par        = even_par({s, in_z});
    assign slot_d_par[0] = (state_q == FULL) ? slot_par[1] : in_par;
    assign slot_d_par[1] = in_par;
    assign out_par       = slot_par[0];
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        result_slot u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (slot_load[i]),
            .d_s   (slot_d_s[i]),
            .d_z   (slot_d_z[i]),
`ifdef OUTPUT_STAGE_PARITY_EN
            .d_par (slot_d_par[i]),
            .q_par (slot_par[i]),
`endif
            .q_s   (slot_s[i]),
            .q_z   (slot_z[i])
        );
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_z     = slot_z[0];
    assign out_s     = slot_s[0];
    assign drop_err  = drop_err_q;
    assign res_count = res_count_q;

endmodule : output_stage

// File: tb/tb_output_stage.sv
// -----------------------------------------------------------------------------
// tb_output_stage
// Self-checking bench for output_stage: a table of directed vectors plus
// hand-written sequences for counter wrap, reset while full and (when
// OUTPUT_STAGE_PARITY_EN is defined) the parity output.
// -----------------------------------------------------------------------------
module tb_output_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       z3, z2, z1, z0;
    logic       s;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_z;
    logic       out_s;
    logic       drop_err;
    logic [7:0] res_count;
`ifdef OUTPUT_STAGE_PARITY_EN
    logic       out_par;
`endif

    int checks   = 0;
    int failures = 0;

    output_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .z3        (z3),
        .z2        (z2),
        .z1        (z1),
        .z0        (z0),
        .s         (s),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_s     (out_s),
`ifdef OUTPUT_STAGE_PARITY_EN
        .out_par   (out_par),
`endif
        .drop_err  (drop_err),
        .res_count (res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] z;
        logic       s;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_z;   // compared only when e_ov = 1
        logic       e_s;   // compared only when e_ov = 1
        logic       e_drop;
        logic [7:0] e_cnt;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] z, input logic sv, input logic ordy);
        in_valid  = iv;
        {z3, z2, z1, z0} = z;
        s         = sv;
        out_ready = ordy;
    endtask

    // Apply current inputs across one rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 1'b0);

        //             iv z      s  ordy  ir ov z      s  drop cnt
        vecs[0]  = '{1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 1'b1, 4'hB, 1'b1, 1'b0, 8'd0}; // push 1011 s=1
        vecs[1]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1}; // pop -> EMPTY
        vecs[2]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 8'd1}; // push 3
        vecs[3]  = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 8'd1}; // push 7 -> FULL
        vecs[4]  = '{1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 8'd1}; // offer 9 -> drop
        vecs[5]  = '{1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 8'd2}; // pop + ignored 9
        vecs[6]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 8'd3}; // pop 7 -> EMPTY
        vecs[7]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 8'd3}; // push 5
        vecs[8]  = '{1'b1, 4'h6, 1'b1, 1'b1, 1'b1, 1'b1, 4'h6, 1'b1, 1'b1, 8'd4}; // push 6 + pop
        vecs[9]  = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 8'd5}; // push A + pop
        vecs[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 8'd5}; // stall: hold A
        vecs[11] = '{1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 8'd5}; // push F -> FULL
        vecs[12] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 8'd6}; // pop A
        vecs[13] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 8'd7}; // pop F -> EMPTY
        vecs[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 8'd7}; // no pop when empty

        // Reset state, observed while rst is held.
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_z",     32'(out_z),     32'd0);
        check("rst_out_s",     32'(out_s),     32'd0);
        check("rst_drop_err",  32'(drop_err),  32'd0);
        check("rst_res_count", 32'(res_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].iv, vecs[i].z, vecs[i].s, vecs[i].ordy);
            tick();
            check($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d_drop_err", i),  32'(drop_err),  32'(vecs[i].e_drop));
            check($sformatf("v%0d_res_count", i), 32'(res_count), 32'(vecs[i].e_cnt));
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d_out_z", i), 32'(out_z), 32'(vecs[i].e_z));
                check($sformatf("v%0d_out_s", i), 32'(out_s), 32'(vecs[i].e_s));
`ifdef OUTPUT_STAGE_PARITY_EN
                check($sformatf("v%0d_out_par", i), 32'(out_par),
                      32'(^{vecs[i].e_s, vecs[i].e_z}));
`endif
            end
        end

        // Counter wrap: one push-only edge, then every edge pushes and pops.
        do_reset();
        drive(1'b1, 4'h2, 1'b0, 1'b1);
        for (int e = 1; e <= 257; e++) begin
            tick();
            if (e == 2)   check("wrap_cnt_1",   32'(res_count), 32'd1);
            if (e == 256) check("wrap_cnt_255", 32'(res_count), 32'd255);
            if (e == 257) check("wrap_cnt_0",   32'(res_count), 32'd0);
        end
        check("wrap_out_valid", 32'(out_valid), 32'd1);

        // Reset while FULL with a nonzero count and drop_err set.
        do_reset();
        drive(1'b1, 4'h1, 1'b0, 1'b1); tick();   // EMPTY -> ONE
        drive(1'b1, 4'h4, 1'b0, 1'b0); tick();   // ONE -> FULL
        drive(1'b1, 4'h8, 1'b0, 1'b1); tick();   // pop 1, drop 8 -> ONE (cnt 1)
        drive(1'b1, 4'hC, 1'b1, 1'b0); tick();   // -> FULL
        drive(1'b1, 4'hD, 1'b0, 1'b0); tick();   // drop again
        check("pre_rst_full",  32'(in_ready),  32'd0);
        check("pre_rst_cnt",   32'(res_count), 32'd1);
        check("pre_rst_drop",  32'(drop_err),  32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_res_count", 32'(res_count), 32'd0);
        check("async_rst_drop_err",  32'(drop_err),  32'd0);
        check("async_rst_in_ready",  32'(in_ready),  32'd1);
        check("async_rst_out_z",     32'(out_z),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 4'hE, 1'b1, 1'b0);
        tick();
        check("post_rst_push_valid", 32'(out_valid), 32'd1);
        check("post_rst_push_z",     32'(out_z),     32'hE);
        check("post_rst_push_s",     32'(out_s),     32'd1);

`ifdef OUTPUT_STAGE_PARITY_EN
        do_reset();
        drive(1'b1, 4'b0111, 1'b0, 1'b0); tick();
        check("par_0111", 32'(out_par), 32'd1);
        drive(1'b1, 4'b0011, 1'b0, 1'b1); tick();
        check("par_0011_z", 32'(out_z),   32'h3);
        check("par_0011",   32'(out_par), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_output_stage

// File: doc/output_stage.md
OUTPUT_STAGE -- requirements
Module: output_stage

Interface
REQ-001 Clock: one clock, clk; reset: rst, asynchronous, active-high; all state resets on rst rising and is held while rst=1.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  z3..z0 and s carry a valid third-stage result this cycle.
REQ-005 z3, z2, z1, z0  input  1 each  residue result bits from the third stage, z3 = MSB.
REQ-006 s  input  1  operation tag travelling with the result: 0 = add, 1 = subtract.
REQ-007 in_ready  output  1  stage can accept a result this cycle.
REQ-008 out_valid  output  1  out_z/out_s hold a result for the consumer.
REQ-009 out_ready  input  1  consumer accepts the presented result.
REQ-010 out_z  output  4  buffered residue; bit 3 = z3.
REQ-011 out_s  output  1  buffered operation tag.
REQ-012 drop_err  output  1  sticky flag: a result was offered while in_ready=0.
REQ-013 res_count  output  8  number of results delivered to the consumer, modulo 256.

Function
REQ-014 Storage shall be a 2-entry FIFO of {s, z[3:0]} with the state machine EMPTY, ONE, FULL.
REQ-015 Push occurs on a clock edge with in_valid=1 and in_ready=1; pop occurs on a clock edge with out_valid=1 and out_ready=1.
REQ-016 in_ready shall be 1 in EMPTY and ONE and 0 in FULL, decoded from registered state only (no combinational path from out_ready).
REQ-017 out_valid shall be 1 in ONE and FULL; out_z/out_s shall always show the oldest entry.
REQ-018 Latency: a result pushed at edge N shall be visible with out_valid=1 after edge N when the FIFO was EMPTY.
REQ-019 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with the new entry at the head; FULL+pop->ONE; all other cases hold.
REQ-020 In FULL, in_valid=1 shall be ignored (no push, even when a pop occurs on the same edge) and shall set drop_err.
REQ-021 out_z/out_s shall stay stable while out_valid=1 and out_ready=0.
REQ-022 res_count shall increment by 1 per pop and wrap from 255 to 0.
REQ-023 drop_err shall clear only on reset.
REQ-024 The stage shall pass residues unchanged and perform no arithmetic on z.

Reset
REQ-025 While rst=1: state=EMPTY, in_ready=1, out_valid=0, out_z=0, out_s=0, drop_err=0, res_count=0.
REQ-026 Reset asserted mid-transfer shall discard all buffered entries; the first edge after rst falls shall accept a push.

Configuration
REQ-027 Macro OUTPUT_STAGE_PARITY_EN: when defined, the stage shall add output out_par (1 bit), equal to the even parity of {out_s, out_z} and stored per entry at push time.
REQ-028 Without OUTPUT_STAGE_PARITY_EN, out_par shall not exist, no parity storage shall be built, and all other behaviour shall be identical.

Structure
REQ-029 Shared package output_stage_pkg shall hold the state type (EMPTY/ONE/FULL), DEPTH=2, Z_W=4 and CNT_W=8.
REQ-030 One sub-module, result_slot, shall hold one {s, z[3:0]} entry (plus parity when enabled), with a load enable; output_stage shall instantiate two of them.

Verification
REQ-031 Reset, then push z=4'b1011, s=1 with out_ready=0 -> next cycle out_valid=1, out_z=1011, out_s=1, in_ready=1.
REQ-032 Push 3, then push 7, out_ready=0 -> FULL, in_ready=0; offer 9 -> drop_err=1; outputs read in order 3, 7 only.
REQ-033 ONE with head 5: push 6 and pop on the same edge -> out_z=6, state ONE, res_count +1.
REQ-034 Stream 256 pops with out_ready=1 -> res_count returns to 0.
REQ-035 Assert rst while FULL -> out_valid=0, res_count=0, drop_err=0 immediately, without waiting for a clock edge.
REQ-036 With OUTPUT_STAGE_PARITY_EN, push z=4'b0111, s=0 -> out_par=1; push z=4'b0011, s=0 -> out_par=0.
